e3_mul_seq: RTL and testbench

E3_MUL_SEQ -- requirements
Module: e3_mul_seq

---
 rtl/e3_pkg.sv | 18 +
 rtl/e3_mul_seq_if.sv | 13 +
 rtl/e3_digit_mac.sv | 23 ++
 rtl/e3_mul_seq.sv | 120 ++++++++++++
 tb/tb_e3_mul_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/e3_pkg.sv
// rtl/e3_pkg.sv - shared state encoding, excess-3 constants and digit check for e3_mul_seq
package e3_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam int         E3_OFFSET = 3;
    localparam logic [3:0] E3_MIN    = 4'h3;
    localparam logic [3:0] E3_MAX    = 4'hC;

    function automatic logic e3_ok(input logic [3:0] d);
        return (d >= E3_MIN) && (d <= E3_MAX);
    endfunction

endpackage

// File: rtl/e3_mul_seq_if.sv
// rtl/e3_mul_seq_if.sv - request/result bundle for e3_mul_seq
interface e3_mul_seq_if #(parameter int DIGITS = 2);
    logic                  start;
    logic [4*DIGITS-1:0]   x;
    logic [3:0]            m;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS+3:0]   y;
    logic                  err;

    modport master (output start, x, m, input busy, done, y, err);
    modport slave  (input start, x, m, output busy, done, y, err);
endinterface

// File: rtl/e3_digit_mac.sv
// rtl/e3_digit_mac.sv - one excess-3 digit multiply-accumulate step
// (x_d-3)*(m-3)+carry, split into an excess-3 result digit and a decimal carry.
module e3_digit_mac
    import e3_pkg::*;
(
    input  logic [3:0] i_xd,
    input  logic [3:0] i_md,
    input  logic [3:0] i_cin,
    output logic [3:0] o_yd,
    output logic [3:0] o_cout
);
    logic [3:0] w_xv;
    logic [3:0] w_mv;
    logic [7:0] w_p;

    always_comb begin
        w_xv   = i_xd - 4'(E3_OFFSET);
        w_mv   = i_md - 4'(E3_OFFSET);
        w_p    = ({4'd0, w_xv} * {4'd0, w_mv}) + {4'd0, i_cin};
        o_yd   = 4'(w_p % 8'd10) + E3_MIN;
        o_cout = 4'(w_p / 8'd10);
    end
endmodule

// File: rtl/e3_mul_seq.sv
// rtl/e3_mul_seq.sv - sequential excess-3 multi-digit by single-digit multiplier
// Optional input digit check enabled by defining E3_MUL_SEQ_CHK_EN.
module e3_mul_seq
    import e3_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    e3_mul_seq_if.slave   bus
);
    localparam int XW = 4 * DIGITS;
    localparam int YW = 4 * DIGITS + 4;
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] LAST = IW'(DIGITS);

    state_t         r_state;
    state_t         w_next;
    logic [XW-1:0]  r_x;
    logic [3:0]     r_m;
    logic [3:0]     r_carry;
    logic [IW-1:0]  r_idx;
    logic [YW-1:0]  r_y;
    logic [3:0]     w_yd;
    logic [3:0]     w_cout;
    logic           w_accept;
    logic           w_bad;

    assign w_accept = (r_state == S_IDLE) && bus.start;

`ifdef E3_MUL_SEQ_CHK_EN
    logic r_err;

    always_comb begin
        w_bad = !e3_ok(bus.m);
        for (int i = 0; i < DIGITS; i++) begin
            if (!e3_ok(bus.x[4*i +: 4])) begin
                w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_bad;
        end
    end

    assign bus.err = r_err;
`else
    assign w_bad   = 1'b0;
    assign bus.err = 1'b0;
`endif

    e3_digit_mac u_mac (
        .i_xd   (r_x[3:0]),
        .i_md   (r_m),
        .i_cin  (r_carry),
        .o_yd   (w_yd),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The final CALC step sees an E3 zero digit, so it emits carry+3 as the top digit.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_bad ? S_FIN : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: w_next = (r_idx == LAST) ? S_FIN : S_CALC;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state != S_IDLE);
        bus.done = (r_state == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_m     <= '0;
            r_carry <= '0;
            r_idx   <= '0;
            r_y     <= {(DIGITS+1){E3_MIN}};
        end else if (w_accept) begin
            r_x     <= bus.x;
            r_m     <= bus.m;
            r_carry <= '0;
            r_idx   <= '0;
            if (w_bad) begin
                r_y <= {(DIGITS+1){E3_MIN}};
            end
        end else if (r_state == S_CALC) begin
            // Result digits enter at the top and shift down, LS digit lands in [3:0].
            r_y     <= YW'({w_yd, r_y} >> 4);
            r_x     <= XW'({E3_MIN, r_x} >> 4);
            r_carry <= w_cout;
            r_idx   <= r_idx + IW'(1);
        end
    end

    assign bus.y = r_y;
endmodule

// File: tb/tb_e3_mul_seq.sv
// tb/tb_e3_mul_seq.sv - directed and exhaustive self-checking bench for e3_mul_seq
module tb_e3_mul_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    e3_mul_seq_if #(.DIGITS(2)) if2 ();
    e3_mul_seq_if #(.DIGITS(3)) if3 ();

    e3_mul_seq #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    e3_mul_seq #(.DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] to_e3(input int v, input int nd);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10 + 3);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic run2(input logic [7:0] x, input logic [3:0] m,
                        output logic [11:0] y, output logic err, output int lat);
        if2.start = 1'b1;
        if2.x     = x;
        if2.m     = m;
        tick();
        if2.start = 1'b0;
        if2.x     = 8'h99;
        if2.m     = 4'h0;
        lat = 0;
        while (!if2.done && lat < 20) begin
            tick();
            lat++;
        end
        check("done_seen", if2.done, 1'b1);
        y   = if2.y;
        err = if2.err;
        tick();
        check("done_single", if2.done, 1'b0);
        check("idle_after", if2.busy, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [3:0]  m;
        logic [11:0] y;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'hCC, 4'hB, 12'hAC5},
        '{8'h7A, 4'h8, 12'h568},
        '{8'h33, 4'h8, 12'h333},
        '{8'h3C, 4'hC, 12'h3B4},
        '{8'hC3, 4'h4, 12'h3C3},
        '{8'hCC, 4'h3, 12'h333}
    };

    initial begin
        logic [11:0] y;
        logic        err;
        int          lat;
        int          ndone;
        logic [11:0] ycap;
        logic [31:0] exp3;

        rst = 1'b1;
        if2.start = 1'b0; if2.x = '0; if2.m = '0;
        if3.start = 1'b0; if3.x = '0; if3.m = '0;
        tick();
        tick();
        check("rst_busy", if2.busy, 1'b0);
        check("rst_done", if2.done, 1'b0);
        check("rst_err", if2.err, 1'b0);
        check("rst_y", if2.y, 12'h333);
        check("rst_y3", if3.y, 16'h3333);
        rst = 1'b0;
        tick();

        // Back-to-back: each run2 returns in the IDLE cycle following FIN.
        foreach (vecs[i]) begin
            run2(vecs[i].x, vecs[i].m, y, err, lat);
            check("vec_y", y, vecs[i].y);
            check("vec_err", err, 1'b0);
            check("vec_lat", lat, 3);
        end
        tick();
        tick();
        check("y_hold", if2.y, 12'h333);

        // Second start during CALC with a different operand must be ignored.
        if2.start = 1'b1; if2.x = 8'hCC; if2.m = 4'hB;
        tick();
        if2.start = 1'b1; if2.x = 8'h44; if2.m = 4'hC;
        tick();
        if2.start = 1'b0;
        ndone = 0;
        ycap  = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if2.done) begin
                ndone++;
                ycap = if2.y;
            end
        end
        check("ign_ndone", ndone, 1);
        check("ign_y", ycap, 12'hAC5);

        // Reset in the middle of CALC aborts without a done pulse.
        if2.start = 1'b1; if2.x = 8'hCC; if2.m = 4'hB;
        tick();
        if2.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", if2.busy, 1'b0);
        check("abort_done", if2.done, 1'b0);
        check("abort_y", if2.y, 12'h333);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if2.done) ndone++;
        end
        check("abort_ndone", ndone, 0);
        run2(8'h7A, 4'h8, y, err, lat);
        check("post_abort_y", y, 12'h568);
        check("post_abort_lat", lat, 3);

`ifdef E3_MUL_SEQ_CHK_EN
        run2(8'h2C, 4'h8, y, err, lat);
        check("chk_lat", lat, 0);
        check("chk_err", err, 1'b1);
        check("chk_y", y, 12'h333);
        run2(8'hCC, 4'hD, y, err, lat);
        check("chk_m_err", err, 1'b1);
        check("chk_m_y", y, 12'h333);
        run2(8'hCC, 4'hB, y, err, lat);
        check("chk_clr_err", err, 1'b0);
        check("chk_clr_y", y, 12'hAC5);
`else
        run2(8'h2C, 4'h8, y, err, lat);
        check("nochk_err", err, 1'b0);
        check("nochk_lat", lat, 3);
`endif

        // Exhaustive three-digit sweep against a decimal model.
        for (int xv = 0; xv < 1000; xv++) begin
            for (int mv = 0; mv < 10; mv++) begin
                exp3 = to_e3(xv * mv, 4);
                if3.start = 1'b1;
                if3.x     = 12'(to_e3(xv, 3));
                if3.m     = 4'(mv + 3);
                tick();
                if3.start = 1'b0;
                lat = 0;
                while (!if3.done && lat < 10) begin
                    tick();
                    lat++;
                end
                if (!if3.done) check("mul3_timeout", if3.done, 1'b1);
                check("mul3_y", if3.y, exp3[15:0]);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
